tdm_frame_scheduler: RTL and testbench
======================================

TDM_FRAME_SCHEDULER -- requirements
Module: tdm_frame_scheduler

Interface
REQ-001 Parameter: CYC_PER_FRAME, 512, c4 cycles per 125 us frame (32 slots x 8 bits x 2 cycles); fixed power of two.
REQ-002 Parameter: LOCK_FRAMES, 2, consecutive correctly spaced f0 edges required to declare lock.
REQ-003 Parameter: MISS_MAX, 2, consecutive missing f0 edges tolerated before losing lock.
REQ-004 Port: c4  in  1  4.096 MHz system clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset; synchronous, active-high.
REQ-006 Port: f0  in  1  active-low frame pulse, synchronous to c4.
REQ-007 Port: select  in  1  0 = tx and rx windows enabled; 1 = rx only, tx suppressed.
REQ-008 Port: cfg_tx_slot  in  5  first tx timeslot.
REQ-009 Port: cfg_tx_len  in  6  tx window length in slots, 0..32; 0 = disabled.
REQ-010 Port: cfg_rx_slot  in  5  first rx timeslot.
REQ-011 Port: cfg_rx_len  in  6  rx window length in slots, 0..32; 0 = disabled.
REQ-012 Port: clk_en_tx / clk_en_rx  out  1 each  converter tx/rx window enables.
REQ-013 Port: clk_tx / clk_rx  out  1 each  2.048 MHz bit clocks, gated by the matching enable.
REQ-014 Port: slot_idx  out  5, bit_idx  out  3  current timeslot and bit position.
REQ-015 Port: frame_start  out  1  one-cycle pulse at cycle 0 of each locked frame.
REQ-016 Port: locked  out  1  frame alignment established.
REQ-017 Port: sync_err  out  1  one-cycle pulse on misplaced f0 edge or loss of lock.

Function
REQ-018 f0 is registered once; an edge is detected in the cycle the registered f0 reads 0 and its previous registered value reads 1.
REQ-019 A 9-bit cycle counter cyc counts 0..511 and wraps; slot = cyc[8:4], bit = cyc[3:1].
REQ-020 States: HUNT, CHECK, LOCKED.
REQ-021 HUNT: cyc is held at 0; on an edge, cyc loads 0 and counts from the next cycle; lock_cnt = 1; go to CHECK.
REQ-022 CHECK: an edge with cyc == 511 increments lock_cnt; at lock_cnt == LOCK_FRAMES go to LOCKED. An edge at any other cyc, or no edge at cyc == 511, pulses sync_err and returns to HUNT.
REQ-023 LOCKED: an edge with cyc == 511 clears miss_cnt. No edge at cyc == 511 increments miss_cnt and the counter flywheels; at miss_cnt == MISS_MAX, pulse sync_err and go to HUNT.
REQ-024 LOCKED: an edge at cyc != 511 pulses sync_err, goes to CHECK, reloads cyc = 0, and sets lock_cnt = 1.
REQ-025 cfg_* and select are captured into shadow registers only at cyc == 0 in LOCKED; mid-frame changes take effect at the next frame.
REQ-026 A slot s is in the tx window when (s - tx_slot) mod 32 < tx_len, using 5-bit wrap-around subtraction; tx_len = 32 covers all slots. The rx window follows the same rule with the rx shadows.
REQ-027 clk_en_tx = locked AND shadow select == 0 AND slot in tx window; clk_en_rx = locked AND slot in rx window.
REQ-028 clk_tx = clk_en_tx term AND cyc[0]; clk_rx likewise. Each bit clock is high in the second c4 cycle of every bit.
REQ-029 All outputs are registered and reflect cyc of the previous cycle (one-cycle latency); frame_start asserts for cyc == 0 while LOCKED.
REQ-030 slot_idx and bit_idx are valid only when locked = 1 and read 0 in HUNT.
REQ-031 On leaving LOCKED, clk_en_*, clk_* and locked deassert on the next cycle; no partial-cycle glitch is permitted.

Reset
REQ-032 While rst = 1 at a rising c4 edge: state = HUNT; cyc, lock_cnt and miss_cnt = 0; shadows = 0; every output = 0.
REQ-033 Assertion of rst mid-frame takes effect at the next c4 edge regardless of state; relock requires LOCK_FRAMES fresh edges.

Verification
REQ-034 Periodic f0 every 512 cycles, tx_slot = 0, tx_len = 31, select = 0 -> locked rises one cycle after the 2nd edge; clk_en_tx high for slots 0..30 (496 cycles), low in slot 31; 248 clk_tx pulses per frame.
REQ-035 rx_slot = 30, rx_len = 4 -> clk_en_rx high in slots 30, 31, 0, 1 across the frame wrap.
REQ-036 In LOCKED, suppress one f0 -> no sync_err and timing unchanged; suppress two consecutive f0 -> sync_err pulse, locked = 0, state HUNT.
REQ-037 In LOCKED, f0 edge at cyc = 100 -> sync_err pulse, locked = 0, cyc restarts at 0 from that edge, and lock is regained after 1 further correct edge.
REQ-038 Change tx_len 31 -> 8 and select 0 -> 1 at cyc = 200 -> current frame unchanged; from the next frame, clk_en_tx stays 0.
REQ-039 Assert rst for one cycle at cyc = 300 in LOCKED -> next cycle all outputs are 0 and the state is HUNT.

Source files
------------

// File: rtl/tdm_frame_scheduler.sv
// TDM frame scheduler: aligns to the f0 frame pulse, flywheels through missed pulses and
// generates per-slot tx/rx converter window enables and gated bit clocks.
module tdm_frame_scheduler #(
    parameter int unsigned CYC_PER_FRAME = 512,
    parameter int unsigned LOCK_FRAMES   = 2,
    parameter int unsigned MISS_MAX      = 2
) (
    input  logic       c4,
    input  logic       rst,
    input  logic       f0,
    input  logic       select,
    input  logic [4:0] cfg_tx_slot,
    input  logic [5:0] cfg_tx_len,
    input  logic [4:0] cfg_rx_slot,
    input  logic [5:0] cfg_rx_len,
    output logic       clk_en_tx,
    output logic       clk_en_rx,
    output logic       clk_tx,
    output logic       clk_rx,
    output logic [4:0] slot_idx,
    output logic [2:0] bit_idx,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    localparam int unsigned CW = $clog2(CYC_PER_FRAME);
    localparam logic [CW-1:0] CycLast = CW'(CYC_PER_FRAME - 1);
    localparam logic [7:0] LockTarget = 8'(LOCK_FRAMES);
    localparam logic [7:0] MissTarget = 8'(MISS_MAX);

    typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [7:0]    lock_cnt_q, lock_cnt_d, lock_inc;
    logic [7:0]    miss_cnt_q, miss_cnt_d, miss_inc;
    logic          f0_q, f0_prev_q;
    logic          f0_edge, at_last, err;

    logic       sel_q, sel_d;
    logic [4:0] tx_slot_q, tx_slot_d, rx_slot_q, rx_slot_d;
    logic [5:0] tx_len_q, tx_len_d, rx_len_q, rx_len_d;
    logic       capture;

    logic [4:0] slot, tx_diff, rx_diff;
    logic       tx_in, rx_in, lk;

    logic       clk_en_tx_d, clk_en_rx_d, clk_tx_d, clk_rx_d;
    logic [4:0] slot_idx_d;
    logic [2:0] bit_idx_d;
    logic       frame_start_d;

    assign f0_edge  = f0_prev_q & ~f0_q;
    assign at_last  = (cyc_q == CycLast);
    assign lock_inc = lock_cnt_q + 8'd1;
    assign miss_inc = miss_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q + CW'(1);
        lock_cnt_d = lock_cnt_q;
        miss_cnt_d = miss_cnt_q;
        err        = 1'b0;
        unique case (state_q)
            StHunt: begin
                cyc_d = '0;
                if (f0_edge) begin
                    lock_cnt_d = 8'd1;
                    miss_cnt_d = 8'd0;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (f0_edge && at_last) begin
                    lock_cnt_d = lock_inc;
                    if (lock_inc >= LockTarget) begin
                        miss_cnt_d = 8'd0;
                        state_d    = StLocked;
                    end
                end else if (f0_edge || at_last) begin
                    err     = 1'b1;
                    cyc_d   = '0;
                    state_d = StHunt;
                end
            end
            StLocked: begin
                if (f0_edge && at_last) begin
                    miss_cnt_d = 8'd0;
                end else if (f0_edge) begin
                    // Misplaced edge: realign to it and re-verify spacing.
                    err        = 1'b1;
                    cyc_d      = '0;
                    lock_cnt_d = 8'd1;
                    state_d    = StCheck;
                end else if (at_last) begin
                    miss_cnt_d = miss_inc;
                    if (miss_inc >= MissTarget) begin
                        err     = 1'b1;
                        cyc_d   = '0;
                        state_d = StHunt;
                    end
                end
            end
            default: begin
                cyc_d   = '0;
                state_d = StHunt;
            end
        endcase
    end

    // Config is sampled once per frame so a window never changes shape mid-frame.
    assign capture   = (state_q == StLocked) && (cyc_q == '0);
    assign sel_d     = capture ? select      : sel_q;
    assign tx_slot_d = capture ? cfg_tx_slot : tx_slot_q;
    assign tx_len_d  = capture ? cfg_tx_len  : tx_len_q;
    assign rx_slot_d = capture ? cfg_rx_slot : rx_slot_q;
    assign rx_len_d  = capture ? cfg_rx_len  : rx_len_q;

    assign slot    = cyc_q[CW-1 -: 5];
    assign tx_diff = slot - tx_slot_d;
    assign rx_diff = slot - rx_slot_d;
    assign tx_in   = ({1'b0, tx_diff} < tx_len_d);
    assign rx_in   = ({1'b0, rx_diff} < rx_len_d);

    // Gating on the next state drops every enable in the cycle right after lock is lost.
    assign lk = (state_d == StLocked);

    always_comb begin
        clk_en_tx_d   = lk & ~sel_d & tx_in;
        clk_en_rx_d   = lk & rx_in;
        clk_tx_d      = clk_en_tx_d & cyc_q[0];
        clk_rx_d      = clk_en_rx_d & cyc_q[0];
        slot_idx_d    = lk ? slot : 5'd0;
        bit_idx_d     = lk ? cyc_q[3:1] : 3'd0;
        frame_start_d = lk && (state_q == StLocked) && (cyc_q == '0);
    end

    always_ff @(posedge c4) begin
        if (rst) begin
            state_q     <= StHunt;
            cyc_q       <= '0;
            lock_cnt_q  <= 8'd0;
            miss_cnt_q  <= 8'd0;
            f0_q        <= 1'b0;
            f0_prev_q   <= 1'b0;
            sel_q       <= 1'b0;
            tx_slot_q   <= 5'd0;
            tx_len_q    <= 6'd0;
            rx_slot_q   <= 5'd0;
            rx_len_q    <= 6'd0;
            clk_en_tx   <= 1'b0;
            clk_en_rx   <= 1'b0;
            clk_tx      <= 1'b0;
            clk_rx      <= 1'b0;
            slot_idx    <= 5'd0;
            bit_idx     <= 3'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            lock_cnt_q  <= lock_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            f0_q        <= f0;
            f0_prev_q   <= f0_q;
            sel_q       <= sel_d;
            tx_slot_q   <= tx_slot_d;
            tx_len_q    <= tx_len_d;
            rx_slot_q   <= rx_slot_d;
            rx_len_q    <= rx_len_d;
            clk_en_tx   <= clk_en_tx_d;
            clk_en_rx   <= clk_en_rx_d;
            clk_tx      <= clk_tx_d;
            clk_rx      <= clk_rx_d;
            slot_idx    <= slot_idx_d;
            bit_idx     <= bit_idx_d;
            frame_start <= frame_start_d;
            locked      <= lk;
            sync_err    <= err;
        end
    end

endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// Directed bench for tdm_frame_scheduler. ph counts c4 cycles since the last sampled f0 pulse;
// outputs seen after cycle ph describe frame cycle ph-2.
module tb_tdm_frame_scheduler;

    logic       c4 = 1'b0;
    logic       rst, f0, select;
    logic [4:0] cfg_tx_slot, cfg_rx_slot;
    logic [5:0] cfg_tx_len, cfg_rx_len;
    logic       clk_en_tx, clk_en_rx, clk_tx, clk_rx;
    logic [4:0] slot_idx;
    logic [2:0] bit_idx;
    logic       frame_start, locked, sync_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ph = 0;
    int cnt_tx, cnt_ctx, cnt_rx, cnt_fs, cnt_err;

    tdm_frame_scheduler dut (
        .c4          (c4),
        .rst         (rst),
        .f0          (f0),
        .select      (select),
        .cfg_tx_slot (cfg_tx_slot),
        .cfg_tx_len  (cfg_tx_len),
        .cfg_rx_slot (cfg_rx_slot),
        .cfg_rx_len  (cfg_rx_len),
        .clk_en_tx   (clk_en_tx),
        .clk_en_rx   (clk_en_rx),
        .clk_tx      (clk_tx),
        .clk_rx      (clk_rx),
        .slot_idx    (slot_idx),
        .bit_idx     (bit_idx),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 c4 = ~c4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c4);
        #1;
        ph = (ph + 1) % 512;
        cnt_tx  += int'(clk_en_tx);
        cnt_ctx += int'(clk_tx);
        cnt_rx  += int'(clk_en_rx);
        cnt_fs  += int'(frame_start);
        cnt_err += int'(sync_err);
    endtask

    task automatic clr();
        cnt_tx = 0; cnt_ctx = 0; cnt_rx = 0; cnt_fs = 0; cnt_err = 0;
    endtask

    task automatic pulse_now();
        f0 = 1'b0;
        tick();
        f0 = 1'b1;
        ph = 0;
    endtask

    task automatic goto(input int p);
        do tick(); while (ph != p);
    endtask

    function automatic logic [31:0] all_out();
        return 32'({locked, frame_start, sync_err, clk_en_tx, clk_en_rx, clk_tx, clk_rx,
                    slot_idx, bit_idx});
    endfunction

    initial begin
        clr();
        rst = 1'b1; f0 = 1'b1; select = 1'b0;
        cfg_tx_slot = 5'd0;  cfg_tx_len = 6'd31;
        cfg_rx_slot = 5'd30; cfg_rx_len = 6'd4;
        tick(); tick();
        chk("reset_outputs", all_out(), 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        chk("hunt_locked", 32'(locked), 32'd0);
        chk("hunt_slot", 32'(slot_idx), 32'd0);

        // Acquire lock with two edges 512 cycles apart
        pulse_now();
        goto(511);
        chk("check_locked", 32'(locked), 32'd0);
        chk("check_slot", 32'(slot_idx), 32'd0);
        pulse_now();
        chk("lock_pre", 32'(locked), 32'd0);
        tick();
        chk("lock_rise", 32'(locked), 32'd1);
        chk("lock_noerr", 32'(sync_err), 32'd0);
        tick();
        chk("fs_cyc0", 32'(frame_start), 32'd1);
        chk("en_tx_s0", 32'(clk_en_tx), 32'd1);
        chk("en_rx_s0", 32'(clk_en_rx), 32'd1);
        chk("clk_tx_c0", 32'(clk_tx), 32'd0);
        tick();
        chk("clk_tx_c1", 32'(clk_tx), 32'd1);
        chk("clk_rx_c1", 32'(clk_rx), 32'd1);
        chk("fs_c1", 32'(frame_start), 32'd0);
        goto(511);
        pulse_now();
        goto(2);

        // Full steady frame: cycles 1..511 then 0
        clr();
        goto(34);
        chk("en_rx_s2", 32'(clk_en_rx), 32'd0);
        chk("slot_s2", 32'(slot_idx), 32'd2);
        goto(497);
        chk("en_tx_s30", 32'(clk_en_tx), 32'd1);
        chk("bit_s30b7", 32'(bit_idx), 32'd7);
        chk("clk_tx_c495", 32'(clk_tx), 32'd1);
        goto(498);
        chk("en_tx_s31", 32'(clk_en_tx), 32'd0);
        chk("en_rx_s31", 32'(clk_en_rx), 32'd1);
        chk("slot_s31", 32'(slot_idx), 32'd31);
        goto(511);
        pulse_now();
        goto(2);
        chk("cnt_en_tx", 32'(cnt_tx), 32'd496);
        chk("cnt_clk_tx", 32'(cnt_ctx), 32'd248);
        chk("cnt_en_rx", 32'(cnt_rx), 32'd64);
        chk("cnt_fs", 32'(cnt_fs), 32'd1);
        chk("cnt_err_steady", 32'(cnt_err), 32'd0);

        // One missing f0 is tolerated
        clr();
        goto(511);
        goto(0);
        goto(2);
        chk("miss1_fs", 32'(frame_start), 32'd1);
        chk("miss1_locked", 32'(locked), 32'd1);
        goto(511);
        pulse_now();
        goto(2);
        chk("miss1_fs_after", 32'(frame_start), 32'd1);
        chk("miss1_err", 32'(cnt_err), 32'd0);

        // Two consecutive missing f0 lose lock
        clr();
        goto(511);
        goto(0);
        goto(511);
        goto(0);
        chk("miss2_pre_locked", 32'(locked), 32'd1);
        goto(1);
        chk("miss2_err", 32'(sync_err), 32'd1);
        chk("miss2_locked", 32'(locked), 32'd0);
        tick();
        chk("miss2_err_pulse", 32'(sync_err), 32'd0);
        chk("miss2_en_tx", 32'(clk_en_tx), 32'd0);
        chk("miss2_err_cnt", 32'(cnt_err), 32'd1);

        // Relock, then a misplaced edge at cyc 100
        pulse_now();
        goto(511);
        pulse_now();
        tick();
        chk("relock", 32'(locked), 32'd1);
        goto(100);
        pulse_now();
        tick();
        chk("misplaced_err", 32'(sync_err), 32'd1);
        chk("misplaced_locked", 32'(locked), 32'd0);
        goto(50);
        chk("misplaced_en_tx", 32'(clk_en_tx), 32'd0);
        goto(511);
        pulse_now();
        tick();
        chk("misplaced_relock", 32'(locked), 32'd1);
        chk("misplaced_relock_err", 32'(sync_err), 32'd0);
        goto(2);
        chk("misplaced_fs", 32'(frame_start), 32'd1);

        // Mid-frame config change only applies from the next frame
        clr();
        goto(202);
        cfg_tx_len = 6'd8;
        select = 1'b1;
        goto(300);
        chk("cfg_cur_en_tx", 32'(clk_en_tx), 32'd1);
        goto(511);
        pulse_now();
        goto(2);
        chk("cfg_cur_cnt_tx", 32'(cnt_tx), 32'd495);
        chk("cfg_cur_cnt_clk", 32'(cnt_ctx), 32'd248);
        clr();
        goto(511);
        pulse_now();
        goto(2);
        chk("cfg_next_cnt_tx", 32'(cnt_tx), 32'd0);
        chk("cfg_next_cnt_clk", 32'(cnt_ctx), 32'd0);
        chk("cfg_next_cnt_rx", 32'(cnt_rx), 32'd64);

        // Synchronous reset mid-frame
        goto(302);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outputs", all_out(), 32'd0);
        repeat (600) tick();
        chk("rst_hunt_locked", 32'(locked), 32'd0);

        // No edge at cyc 511 while checking returns to hunt
        pulse_now();
        goto(0);
        goto(1);
        chk("check_miss_err", 32'(sync_err), 32'd1);
        chk("check_miss_locked", 32'(locked), 32'd0);

        // Relock needs two fresh edges
        pulse_now();
        goto(511);
        chk("rst_relock_pre", 32'(locked), 32'd0);
        pulse_now();
        tick();
        chk("rst_relock", 32'(locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
